minv_step_ctrl: RTL and testbench
=================================

# minv_step_ctrl

Sequencer for the modular-inverse datapath in the MINV/MDIV coprocessor. It loads operands and paces the iteration unit one step at a time through a request/acknowledge handshake. It ping-pongs source and destination between regx1 and regx2 on every step. On completion it commits to the minv flag register which of the two registers holds the result.

## Interface
Parameters:
- MAX_ITER, 512, step limit before timeout (2 × 256-bit operand)
- CNT_W, $clog2(MAX_ITER+1), width of iteration counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- abort  in  1  cancel operation; sampled in any non-IDLE state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse (success or timeout)
- err  out  1  timeout flag; sticky until next accepted start
- load_we  out  1  one-cycle operand load into regx1
- src_sel  out  1  register read this step (0 = regx1, 1 = regx2)
- dst_sel  out  1  register written this step; always ~src_sel
- step_req  out  1  request one iteration
- step_ack  in  1  iteration finished; destination written this cycle
- step_last  in  1  qualifies step_ack; the step just finished was the final one
- minv_flag_we  out  1  write enable to minv flag register
- minv_flag_in  out  1  flag value: register holding minv
- iter_cnt  out  CNT_W  steps completed in current operation

## Operation
- States: IDLE, LOAD, STEP, COMMIT, ERR.
- IDLE: start=1 → LOAD. The same edge clears err, iter_cnt and src_sel.
- LOAD: load_we=1 and src_sel=0 for exactly one cycle → STEP.
- STEP: step_req=1 until step_ack.
  - On step_ack, iter_cnt increments and src_sel toggles at the next edge.
  - step_ack & step_last → COMMIT.
  - step_ack & !step_last & iter_cnt+1 == MAX_ITER → ERR (timeout macro only).
  - Otherwise stay in STEP.
- COMMIT: minv_flag_we=1, minv_flag_in=src_sel (the last destination), done=1 for one cycle → IDLE.
- ERR: err set, done=1 for one cycle, minv_flag_we stays 0 → IDLE.
- abort in LOAD, STEP or COMMIT → IDLE at the next edge.
  - abort has priority over step_ack and over that cycle's commit; minv_flag_we and done are suppressed.
  - err is not set; iter_cnt holds its value.
- start while busy: ignored.
- step_ack while step_req=0: ignored.
- step_last without step_ack: ignored.
- Odd step count leaves the result in regx2 (flag 1). Even step count leaves it in regx1 (flag 0).

## Timing
- Reset values: state IDLE; busy, done, err, load_we, step_req, minv_flag_we, minv_flag_in, src_sel all 0; dst_sel 1; iter_cnt 0.
- rst_n low during an operation → next edge returns to reset values; no commit.
- All outputs are registered or decoded from state only. There is no combinational path from step_ack to step_req.
- Cycle latency, with start at edge 0:
  - load_we high in cycle 1.
  - step_req high from cycle 2.
- With a same-cycle ack on every step, N steps give:
  - last ack in cycle 1+N;
  - COMMIT (minv_flag_we, done) in cycle 2+N;
  - busy low in cycle 3+N.
- step_req drops in the cycle after an ack only when leaving STEP. Back-to-back steps keep step_req high.

## Configuration
- MINV_STEP_CTRL_TIMEOUT_EN defined: MAX_ITER check active; ERR state reachable.
- Not defined:
  - no limit; iter_cnt wraps modulo 2^CNT_W;
  - ERR state absent; err tied 0;
  - the operation ends only on step_last or abort.

## Structure
- Shared package minv_pkg holds:
  - state enum minv_step_state_t;
  - constants SEL_REGX1=1'b0 and SEL_REGX2=1'b1;
  - default MAX_ITER.
- One sub-module, minv_iter_cnt, holds the counter:
  - inputs: clear, increment;
  - outputs: iter_cnt, limit-reached compare (compare compiled under the macro).
- The flag register itself stays a separate instance driven by minv_flag_we and minv_flag_in.

## Test plan
- Reset: hold rst_n=0 mid-STEP → next cycle all outputs at reset values; minv_flag_we never pulses.
- Three steps, immediate ack: start at edge 0.
  - load_we in cycle 1.
  - acks in cycles 2–4 with src_sel 0,1,0.
  - Cycle 5: minv_flag_we=1, minv_flag_in=1, done=1, iter_cnt=3.
- Four steps: same stimulus with step_last on the 4th ack → minv_flag_in=0, iter_cnt=4.
- Stall: step_ack held low for 5 cycles → step_req stays 1; iter_cnt and src_sel unchanged. A second start in this window is ignored.
- Abort: abort asserted together with step_ack & step_last → IDLE next cycle; no minv_flag_we, no done, err=0.
- Timeout (macro on, MAX_ITER=8): never assert step_last → after the 8th ack, err=1 and done=1 for one cycle; no minv_flag_we. The next start clears err.

Source files
------------

// File: rtl/minv_pkg.sv
// minv_pkg: shared types and constants for the modular-inverse step sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minv_pkg;

  // Default step limit: two passes over a 256-bit operand.
  localparam int DEF_MAX_ITER = 512;

  // Register select encoding for src_sel / dst_sel / minv_flag_in.
  localparam logic SEL_REGX1 = 1'b0;
  localparam logic SEL_REGX2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERR    = 3'd4
  } minv_step_state_t;

endpackage

// File: rtl/minv_iter_cnt.sv
// minv_iter_cnt: iteration counter with synchronous clear and single-step increment.
// Latency: count updates on the edge after clr/inc; limit_hit is decoded from the count.
// Backpressure: none; increments only when the sequencer accepts a step.
// limit_hit exists only when MINV_STEP_CTRL_TIMEOUT_EN is defined; otherwise the count wraps.
module minv_iter_cnt
  import minv_pkg::*;
#(
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
`ifdef MINV_STEP_CTRL_TIMEOUT_EN
  output logic             limit_hit,
`endif
  output logic [CNT_W-1:0] iter_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign iter_cnt = cnt_q;

`ifdef MINV_STEP_CTRL_TIMEOUT_EN
  // True when the step being acknowledged now would be the MAX_ITER-th one.
  assign limit_hit = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(MAX_ITER));
`endif

endmodule

// File: rtl/minv_step_ctrl.sv
// minv_step_ctrl: loads operands, paces the iteration unit step by step, ping-pongs regx1/regx2, commits result location.
// Latency: load_we 1 cycle after start, step_req from cycle 2, commit 1 cycle after the last ack.
// Backpressure: step_req held until step_ack; back-to-back acks keep step_req high.
// Optional step-limit timeout (ERR state) enabled by defining MINV_STEP_CTRL_TIMEOUT_EN.
module minv_step_ctrl
  import minv_pkg::*;
#(
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             load_we,
  output logic             src_sel,
  output logic             dst_sel,
  output logic             step_req,
  input  logic             step_ack,
  input  logic             step_last,
  output logic             minv_flag_we,
  output logic             minv_flag_in,
  output logic [CNT_W-1:0] iter_cnt
);

  minv_step_state_t state_q, state_d;
  logic src_sel_q, src_sel_d;
  logic err_q, err_d;
  logic flag_in_q, flag_in_d;
  logic busy_q, load_we_q, step_req_q, flag_we_q, done_q;
  logic cnt_clr, cnt_inc;
`ifdef MINV_STEP_CTRL_TIMEOUT_EN
  logic limit_hit;
`endif

  minv_iter_cnt #(
    .MAX_ITER (MAX_ITER),
    .CNT_W    (CNT_W)
  ) u_iter_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
`ifdef MINV_STEP_CTRL_TIMEOUT_EN
    .limit_hit (limit_hit),
`endif
    .iter_cnt  (iter_cnt)
  );

  // Next-state logic; abort outranks step_ack so an aborted step never commits or counts.
  always_comb begin
    state_d   = state_q;
    src_sel_d = src_sel_q;
    err_d     = err_q;
    flag_in_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          err_d     = 1'b0;
          src_sel_d = SEL_REGX1;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = abort ? ST_IDLE : ST_STEP;
      end
      ST_STEP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (step_ack) begin
          cnt_inc   = 1'b1;
          src_sel_d = ~src_sel_q;
          if (step_last) begin
            // The register just written (old dst) holds the result.
            state_d   = ST_COMMIT;
            flag_in_d = ~src_sel_q;
`ifdef MINV_STEP_CTRL_TIMEOUT_EN
          end else if (limit_hit) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
`endif
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
`ifdef MINV_STEP_CTRL_TIMEOUT_EN
      ST_ERR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_sel_q  <= SEL_REGX1;
      err_q      <= 1'b0;
      flag_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      load_we_q  <= 1'b0;
      step_req_q <= 1'b0;
      flag_we_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_sel_q  <= src_sel_d;
      err_q      <= err_d;
      flag_in_q  <= flag_in_d;
      busy_q     <= (state_d != ST_IDLE);
      load_we_q  <= (state_d == ST_LOAD);
      step_req_q <= (state_d == ST_STEP);
      flag_we_q  <= (state_d == ST_COMMIT);
      done_q     <= (state_d == ST_COMMIT) || (state_d == ST_ERR);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign load_we      = load_we_q;
  assign src_sel      = src_sel_q;
  assign dst_sel      = ~src_sel_q;
  assign step_req     = step_req_q;
  assign minv_flag_we = flag_we_q;
  assign minv_flag_in = flag_in_q;

endmodule

// File: tb/tb_minv_step_ctrl.sv
// tb_minv_step_ctrl: directed checks of the step sequencer against hand-computed cycle timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_minv_step_ctrl;

  localparam int MAX_ITER = 8;
  localparam int CNT_W    = $clog2(MAX_ITER + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic             load_we;
  logic             src_sel;
  logic             dst_sel;
  logic             step_req;
  logic             step_ack;
  logic             step_last;
  logic             minv_flag_we;
  logic             minv_flag_in;
  logic [CNT_W-1:0] iter_cnt;

  int n_chk;
  int n_bad;

  minv_step_ctrl #(
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .load_we      (load_we),
    .src_sel      (src_sel),
    .dst_sel      (dst_sel),
    .step_req     (step_req),
    .step_ack     (step_ack),
    .step_last    (step_last),
    .minv_flag_we (minv_flag_we),
    .minv_flag_in (minv_flag_in),
    .iter_cnt     (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start from IDLE and land in the first STEP cycle.
  task automatic start_op();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_we", {31'd0, load_we}, 32'd1);
    chk("load_src", {31'd0, src_sel}, 32'd0);
    tick();
    chk("step_req_on", {31'd0, step_req}, 32'd1);
  endtask

  // One step with the ack in the current cycle.
  task automatic step_once(input logic last);
    step_ack  = 1'b1;
    step_last = last;
    tick();
    step_ack  = 1'b0;
    step_last = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    step_ack  = 1'b0;
    step_last = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset values.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dst", {31'd0, dst_sel}, 32'd1);
    chk("rst_cnt", 32'(iter_cnt), 32'd0);

    // Three steps, immediate ack: src_sel 0,1,0 then commit flag 1.
    start_op();
    chk("s3_src0", {31'd0, src_sel}, 32'd0);
    step_once(1'b0);
    chk("s3_src1", {31'd0, src_sel}, 32'd1);
    chk("s3_dst1", {31'd0, dst_sel}, 32'd0);
    step_once(1'b0);
    chk("s3_src2", {31'd0, src_sel}, 32'd0);
    chk("s3_req_b2b", {31'd0, step_req}, 32'd1);
    step_once(1'b1);
    chk("s3_flag_we", {31'd0, minv_flag_we}, 32'd1);
    chk("s3_flag_in", {31'd0, minv_flag_in}, 32'd1);
    chk("s3_done", {31'd0, done}, 32'd1);
    chk("s3_cnt", 32'(iter_cnt), 32'd3);
    chk("s3_req_off", {31'd0, step_req}, 32'd0);
    tick();
    chk("s3_busy_off", {31'd0, busy}, 32'd0);
    chk("s3_done_off", {31'd0, done}, 32'd0);
    chk("s3_we_off", {31'd0, minv_flag_we}, 32'd0);

    // Four steps: even count leaves the result in regx1.
    start_op();
    chk("s4_cnt_clr", 32'(iter_cnt), 32'd0);
    for (int i = 0; i < 3; i++) step_once(1'b0);
    step_once(1'b1);
    chk("s4_flag_we", {31'd0, minv_flag_we}, 32'd1);
    chk("s4_flag_in", {31'd0, minv_flag_in}, 32'd0);
    chk("s4_cnt", 32'(iter_cnt), 32'd4);
    tick();

    // Stall: no ack for 5 cycles, a stray start and a lone step_last are ignored.
    start_op();
    for (int i = 0; i < 5; i++) begin
      start     = (i == 2);
      step_last = (i == 3);
      tick();
      chk("stall_req", {31'd0, step_req}, 32'd1);
      chk("stall_cnt", 32'(iter_cnt), 32'd0);
      chk("stall_src", {31'd0, src_sel}, 32'd0);
      chk("stall_load", {31'd0, load_we}, 32'd0);
      chk("stall_done", {31'd0, done}, 32'd0);
    end
    start     = 1'b0;
    step_last = 1'b0;
    step_once(1'b1);
    chk("stall_flag_in", {31'd0, minv_flag_in}, 32'd1);
    chk("stall_cnt_end", 32'(iter_cnt), 32'd1);
    tick();

    // Abort together with ack & last: no commit, count holds.
    start_op();
    step_once(1'b0);
    abort     = 1'b1;
    step_ack  = 1'b1;
    step_last = 1'b1;
    tick();
    abort     = 1'b0;
    step_ack  = 1'b0;
    step_last = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we", {31'd0, minv_flag_we}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_cnt", 32'(iter_cnt), 32'd1);
    tick();
    chk("abort_we2", {31'd0, minv_flag_we}, 32'd0);

    // Reset mid-STEP returns everything to reset values.
    start_op();
    step_once(1'b0);
    step_once(1'b0);
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_req", {31'd0, step_req}, 32'd0);
    chk("mrst_src", {31'd0, src_sel}, 32'd0);
    chk("mrst_dst", {31'd0, dst_sel}, 32'd1);
    chk("mrst_cnt", 32'(iter_cnt), 32'd0);
    chk("mrst_we", {31'd0, minv_flag_we}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mrst_we2", {31'd0, minv_flag_we}, 32'd0);

    // Step limit: 8 acks without step_last.
    start_op();
    for (int i = 0; i < MAX_ITER; i++) step_once(1'b0);
`ifdef MINV_STEP_CTRL_TIMEOUT_EN
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_we", {31'd0, minv_flag_we}, 32'd0);
    chk("to_cnt", 32'(iter_cnt), 32'd8);
    tick();
    chk("to_busy_off", {31'd0, busy}, 32'd0);
    chk("to_done_off", {31'd0, done}, 32'd0);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_clr", {31'd0, err}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("to_abort_busy", {31'd0, busy}, 32'd0);
`else
    chk("nolim_req", {31'd0, step_req}, 32'd1);
    chk("nolim_err", {31'd0, err}, 32'd0);
    chk("nolim_done", {31'd0, done}, 32'd0);
    chk("nolim_cnt", 32'(iter_cnt), 32'd8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("nolim_abort", {31'd0, busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
